ysyx_25030081_mc_ctrl: RTL and testbench
========================================

// Module: ysyx_25030081_mc_ctrl
// PURPOSE
//  Multi-cycle sequencer for the NPC core. Fetches over a valid/ready IMEM port, latches IR, decodes the opcode.
//  Drives ext_op to the immediate extender, plus PC/RF write enables and the DMEM handshake for loads and stores.
//  Sits between the memory ports and the datapath. Retires exactly one instruction per WB visit.
// PARAMETERS
//  DATA_WIDTH   32   width of IR and immediate datapath
//  MEM_TIMEOUT  256  max cycles in IWAIT/MWAIT before timeout (trap build only); >=2
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   reset, synchronous, active-low
//  imem_req_valid  out  1   fetch request
//  imem_req_ready  in   1   IMEM accepts request
//  imem_rsp_valid  in   1   fetch data valid
//  imem_rdata      in   32  fetched instruction
//  dmem_req_valid  out  1   load/store request
//  dmem_req_ready  in   1   DMEM accepts request
//  dmem_we         out  1   1=store, 0=load; valid with dmem_req_valid
//  dmem_rsp_valid  in   1   load data valid / store done
//  branch_taken    in   1   EXU compare result, sampled in EXEC
//  inst            out  32  registered IR
//  ext_op          out  3   000 I, 001 U, 010 S, 011 B, 100 J
//  pc_we           out  1   PC update strobe (1 cycle, in WB)
//  pc_sel          out  1   0=pc+4, 1=target (JAL/JALR/taken branch)
//  rf_we           out  1   regfile write strobe (1 cycle, in WB)
//  retire          out  1   1-cycle pulse per retired instruction
//  halt            out  1   sticky; set on EBREAK (0x00100073)
//  trap            out  1   sticky; trap build only, else tied 0
// BEHAVIOUR
//  Reset (rst_n=0 at edge, any state): state->IDLE; IR=0x00000013; all strobes, halt, trap = 0; timeout counter = 0.
//  Reset mid-handshake drops req_valid immediately. Memories must tolerate an abandoned request.
//  States: IDLE->FETCH (1 cycle). FETCH: imem_req_valid=1 until imem_req_ready, then ->IWAIT.
//   IWAIT: on imem_rsp_valid latch IR, ->DECODE. DECODE: 1 cycle, ->EXEC, or ->HALT on EBREAK.
//   EXEC: 1 cycle, capture pc_sel. LOAD/STORE ->MREQ; else ->WB.
//   MREQ: dmem_req_valid=1, dmem_we=(STORE), until dmem_req_ready, then ->MWAIT.
//   MWAIT: on dmem_rsp_valid ->WB. WB: pc_we=1, rf_we per opcode, retire=1, ->FETCH.
//   HALT: absorbing until reset.
//  Valid/ready: req_valid and dmem_we stay stable while valid&&!ready. A same-cycle valid&&ready counts as a transfer.
//  imem/dmem rsp_valid outside IWAIT/MWAIT is ignored.
//  ext_op is combinational from IR[6:0]: LOAD/OP-IMM/JALR=000, LUI/AUIPC=001, STORE=010, BRANCH=011, JAL=100.
//   All other opcodes give 000.
//  rf_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP. rf_we=0 for BRANCH, STORE, SYSTEM.
//  pc_sel=1 for JAL and JALR; for BRANCH pc_sel=branch_taken; else 0. Held from EXEC through WB.
//  Minimum latency: 5 cycles for non-memory instructions (FETCH..WB, zero-wait memory), 7 cycles for load/store.
//  Non-EBREAK SYSTEM (ECALL, CSR) retires as NOP.
// CONFIGURATION
//  YSYX_25030081_CTRL_TRAP_EN defined:
//   - Unknown opcode in DECODE ->TRAP.
//   - Counter reaching MEM_TIMEOUT in IWAIT or MWAIT ->TRAP.
//   - TRAP state: trap=1, no strobes, absorbing until reset. Counter clears on each entry to IWAIT or MWAIT.
//  Undefined: unknown opcode retires as NOP (pc+4, rf_we=0). No counter logic; trap=0 constant.
// TESTING
//  ADDI 0x00500093, zero-wait memories -> ext_op=000; pc_we=rf_we=retire=1 exactly in 5th cycle after FETCH entry.
//  LW, dmem_req_ready low 3 cycles -> dmem_req_valid held 4 cycles with dmem_we=0; retire after rsp; rf_we=1.
//  BEQ with branch_taken=1 -> ext_op=011, pc_sel=1, rf_we=0 in WB. SW -> ext_op=010, dmem_we=1, rf_we=0.
//  EBREAK 0x00100073 -> halt=1 from cycle after DECODE; no further imem_req_valid; retire never pulses.
//  rst_n=0 during MREQ -> next cycle dmem_req_valid=0, state IDLE, inst=0x00000013; FETCH follows 1 cycle after release.
//  TRAP_EN: opcode 0x7F -> trap=1, no retire. IMEM rsp withheld 256 cycles -> trap=1. Undefined build: same cases give NOP / keep waiting.

Source files
------------

// File: rtl/ysyx_25030081_mc_ctrl_if.sv
// Memory handshakes and datapath controls between the NPC sequencer and its environment.
// master = sequencer side, slave = memories/datapath side.
interface ysyx_25030081_mc_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  dmem_req_valid;
    logic                  dmem_req_ready;
    logic                  dmem_we;
    logic                  dmem_rsp_valid;
    logic                  branch_taken;
    logic [DATA_WIDTH-1:0] inst;
    logic [2:0]            ext_op;
    logic                  pc_we;
    logic                  pc_sel;
    logic                  rf_we;
    logic                  retire;
    logic                  halt;
    logic                  trap;

    modport master (
        output imem_req_valid, input imem_req_ready, input imem_rsp_valid, input imem_rdata,
        output dmem_req_valid, input dmem_req_ready, output dmem_we, input dmem_rsp_valid,
        input branch_taken,
        output inst, output ext_op, output pc_we, output pc_sel, output rf_we,
        output retire, output halt, output trap
    );

    modport slave (
        input imem_req_valid, output imem_req_ready, output imem_rsp_valid, output imem_rdata,
        input dmem_req_valid, output dmem_req_ready, input dmem_we, output dmem_rsp_valid,
        output branch_taken,
        input inst, input ext_op, input pc_we, input pc_sel, input rf_we,
        input retire, input halt, input trap
    );
endinterface

// File: rtl/ysyx_25030081_mc_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the NPC core; one retire per WB visit.
// Define YSYX_25030081_CTRL_TRAP_EN to trap on unknown opcodes and memory-wait timeouts.
module ysyx_25030081_mc_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_TIMEOUT = 256
) (
    input logic                     clk,
    input logic                     rst_n,
    ysyx_25030081_mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        StIdle, StFetch, StIWait, StDecode, StExec, StMReq, StMWait, StWb, StHalt, StTrap
    } stateT;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [DATA_WIDTH-1:0] IrNop    = DATA_WIDTH'(32'h00000013);
    localparam logic [DATA_WIDTH-1:0] IrEbreak = DATA_WIDTH'(32'h00100073);

    stateT                 stateQ;
    logic [DATA_WIDTH-1:0] irQ;
    logic imemReqValidQ, dmemReqValidQ, dmemWeQ, pcWeQ, pcSelQ, rfWeQ, retireQ, haltQ;

    logic [6:0] opcode;
    logic [2:0] extOp;
    logic       writesRd, isKnown, isJump, isMem;

    assign opcode = irQ[6:0];
    assign isJump = (opcode == OpJal) || (opcode == OpJalr);
    assign isMem  = (opcode == OpLoad) || (opcode == OpStore);

    always_comb begin
        extOp    = 3'b000;
        writesRd = 1'b0;
        isKnown  = 1'b1;
        case (opcode)
            OpLoad, OpImm, OpJalr, OpOp: writesRd = 1'b1;
            OpLui, OpAuipc: begin
                extOp    = 3'b001;
                writesRd = 1'b1;
            end
            OpStore:  extOp = 3'b010;
            OpBranch: extOp = 3'b011;
            OpJal: begin
                extOp    = 3'b100;
                writesRd = 1'b1;
            end
            OpSystem: ;
            default:  isKnown = 1'b0;
        endcase
    end

`ifdef YSYX_25030081_CTRL_TRAP_EN
    localparam int unsigned CntW = $clog2(MEM_TIMEOUT);
    logic [CntW-1:0] waitCntQ;
    logic            trapQ;
    logic            timeout;
    // Counter holds the number of wait cycles already spent in IWAIT/MWAIT.
    assign timeout = (waitCntQ == CntW'(MEM_TIMEOUT - 1));
`else
    logic unusedCfg;
    assign unusedCfg = ^{32'(MEM_TIMEOUT), isKnown};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ        <= StIdle;
            irQ           <= IrNop;
            imemReqValidQ <= 1'b0;
            dmemReqValidQ <= 1'b0;
            dmemWeQ       <= 1'b0;
            pcWeQ         <= 1'b0;
            pcSelQ        <= 1'b0;
            rfWeQ         <= 1'b0;
            retireQ       <= 1'b0;
            haltQ         <= 1'b0;
`ifdef YSYX_25030081_CTRL_TRAP_EN
            trapQ         <= 1'b0;
            waitCntQ      <= '0;
`endif
        end else begin
            pcWeQ   <= 1'b0;
            rfWeQ   <= 1'b0;
            retireQ <= 1'b0;
            case (stateQ)
                StIdle: begin
                    stateQ        <= StFetch;
                    imemReqValidQ <= 1'b1;
                end
                StFetch: if (bus.imem_req_ready) begin
                    imemReqValidQ <= 1'b0;
                    stateQ        <= StIWait;
`ifdef YSYX_25030081_CTRL_TRAP_EN
                    waitCntQ      <= '0;
`endif
                end
                StIWait: begin
                    if (bus.imem_rsp_valid) begin
                        irQ    <= bus.imem_rdata;
                        stateQ <= StDecode;
                    end
`ifdef YSYX_25030081_CTRL_TRAP_EN
                    else if (timeout) begin
                        stateQ <= StTrap;
                        trapQ  <= 1'b1;
                    end else begin
                        waitCntQ <= waitCntQ + CntW'(1);
                    end
`endif
                end
                StDecode: begin
                    if (irQ == IrEbreak) begin
                        stateQ <= StHalt;
                        haltQ  <= 1'b1;
                    end
`ifdef YSYX_25030081_CTRL_TRAP_EN
                    else if (!isKnown) begin
                        stateQ <= StTrap;
                        trapQ  <= 1'b1;
                    end
`endif
                    else begin
                        stateQ <= StExec;
                    end
                end
                StExec: begin
                    pcSelQ <= isJump || ((opcode == OpBranch) && bus.branch_taken);
                    if (isMem) begin
                        stateQ        <= StMReq;
                        dmemReqValidQ <= 1'b1;
                        dmemWeQ       <= (opcode == OpStore);
                    end else begin
                        stateQ  <= StWb;
                        pcWeQ   <= 1'b1;
                        rfWeQ   <= writesRd;
                        retireQ <= 1'b1;
                    end
                end
                StMReq: if (bus.dmem_req_ready) begin
                    dmemReqValidQ <= 1'b0;
                    dmemWeQ       <= 1'b0;
                    stateQ        <= StMWait;
`ifdef YSYX_25030081_CTRL_TRAP_EN
                    waitCntQ      <= '0;
`endif
                end
                StMWait: begin
                    if (bus.dmem_rsp_valid) begin
                        stateQ  <= StWb;
                        pcWeQ   <= 1'b1;
                        rfWeQ   <= writesRd;
                        retireQ <= 1'b1;
                    end
`ifdef YSYX_25030081_CTRL_TRAP_EN
                    else if (timeout) begin
                        stateQ <= StTrap;
                        trapQ  <= 1'b1;
                    end else begin
                        waitCntQ <= waitCntQ + CntW'(1);
                    end
`endif
                end
                StWb: begin
                    stateQ        <= StFetch;
                    imemReqValidQ <= 1'b1;
                    pcSelQ        <= 1'b0;
                end
                default: ;  // HALT and TRAP hold until reset
            endcase
        end
    end

    assign bus.imem_req_valid = imemReqValidQ;
    assign bus.dmem_req_valid = dmemReqValidQ;
    assign bus.dmem_we        = dmemWeQ;
    assign bus.inst           = irQ;
    assign bus.ext_op         = extOp;
    assign bus.pc_we          = pcWeQ;
    assign bus.pc_sel         = pcSelQ;
    assign bus.rf_we          = rfWeQ;
    assign bus.retire         = retireQ;
    assign bus.halt           = haltQ;
`ifdef YSYX_25030081_CTRL_TRAP_EN
    assign bus.trap           = trapQ;
`else
    assign bus.trap           = 1'b0;
`endif
endmodule

// File: tb/tb_ysyx_25030081_mc_ctrl.sv
// Directed bench for ysyx_25030081_mc_ctrl: per-instruction expectations from the ISA tables,
// a per-cycle compare process, and literal checks for the headline cases.
module tb_ysyx_25030081_mc_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_25030081_mc_ctrl_if bus ();
    ysyx_25030081_mc_ctrl #(.DATA_WIDTH(32), .MEM_TIMEOUT(256)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [31:0] ir;
        logic        pcSel;
    } expT;

    expT expQ[$];
    int  nTests = 0;
    int  nFail = 0;
    int  cyc = 0;
    bit  checkEn = 1'b0;
    bit  haltSeen = 1'b0;
    bit  trapSeen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] expExtOp(input logic [31:0] ir);
        case (ir[6:0])
            7'h37, 7'h17: return 3'b001;
            7'h23:        return 3'b010;
            7'h63:        return 3'b011;
            7'h6F:        return 3'b100;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic logic expRfWe(input logic [31:0] ir);
        case (ir[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic expPcSel(input logic [31:0] ir, input logic taken);
        if (ir[6:0] == 7'h6F || ir[6:0] == 7'h67) return 1'b1;
        if (ir[6:0] == 7'h63) return taken;
        return 1'b0;
    endfunction

    function automatic bit isMemOp(input logic [31:0] ir);
        return ir[6:0] == 7'h03 || ir[6:0] == 7'h23;
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.imem_req_valid;
            1:       return bus.dmem_req_valid;
            default: return bus.retire;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        expT e;
        if (checkEn) begin
            chk("ext_op", 32'(bus.ext_op), 32'(expExtOp(bus.inst)));
            chk("pc_we_with_retire", 32'(bus.pc_we), 32'(bus.retire));
            chk("rf_we", 32'(bus.rf_we), 32'(bus.retire && expRfWe(bus.inst)));
            if (bus.retire === 1'b1) begin
                nTests++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("FAIL retire_unexpected: got retire with inst 0x%0h, expected none",
                             bus.inst);
                end else begin
                    e = expQ.pop_front();
                    chk("retire_inst", bus.inst, e.ir);
                    chk("retire_pc_sel", 32'(bus.pc_sel), 32'(e.pcSel));
                end
            end
            if (haltSeen) begin
                chk("halt_sticky", 32'(bus.halt), 32'd1);
                chk("no_fetch_after_halt", 32'(bus.imem_req_valid), 32'd0);
            end
            haltSeen = haltSeen | (bus.halt === 1'b1);
`ifdef YSYX_25030081_CTRL_TRAP_EN
            if (trapSeen) begin
                chk("trap_sticky", 32'(bus.trap), 32'd1);
                chk("no_fetch_after_trap", 32'(bus.imem_req_valid), 32'd0);
            end
            trapSeen = trapSeen | (bus.trap === 1'b1);
`else
            chk("trap_tied_low", 32'(bus.trap), 32'd0);
`endif
        end
    end

    task automatic waitFor(input string name, input int sel);
        int n = 0;
        while (sig(sel) !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        nTests++;
        if (sig(sel) !== 1'b1) begin
            nFail++;
            $display("FAIL %s: still low after %0d cycles, required high", name, n);
        end
    endtask

    task automatic doReset();
        checkEn = 1'b0;
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rdata = '0;
        bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0; bus.branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_inst", bus.inst, 32'h00000013);
        chk("rst_imem_req", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_dmem_req", 32'(bus.dmem_req_valid), 32'd0);
        chk("rst_strobes", 32'({bus.pc_we, bus.rf_we, bus.retire}), 32'd0);
        chk("rst_halt_trap", 32'({bus.halt, bus.trap}), 32'd0);
        expQ.delete();
        haltSeen = 1'b0;
        trapSeen = 1'b0;
        rst_n = 1'b1;
        checkEn = 1'b1;
        @(negedge clk);
        chk("fetch_after_release", 32'(bus.imem_req_valid), 32'd1);
    endtask

    // Leaves the DUT in DECODE at return. Junk responses during FETCH must be ignored.
    task automatic fetch(input logic [31:0] ir, input int iw, input int rw, input logic taken,
                         input bit push, output int t0);
        waitFor("fetch_req", 0);
        t0 = cyc;
        if (push) expQ.push_back('{ir: ir, pcSel: expPcSel(ir, taken)});
        for (int i = 0; i < iw; i++) begin
            bus.imem_req_ready = 1'b0;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("imem_req_hold", 32'(bus.imem_req_valid), 32'd1);
        end
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        chk("imem_req_drop", 32'(bus.imem_req_valid), 32'd0);
        for (int i = 0; i < rw; i++) @(negedge clk);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata = ir;
        bus.branch_taken = taken;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rdata = '0;
    endtask

    task automatic memPhase(input logic store, input int dw, input int dr, output int held);
        waitFor("dmem_req", 1);
        held = 1;
        chk("dmem_we", 32'(bus.dmem_we), 32'(store));
        for (int i = 0; i < dw; i++) begin
            bus.dmem_req_ready = 1'b0;
            bus.dmem_rsp_valid = 1'b1;
            @(negedge clk);
            if (bus.dmem_req_valid === 1'b1) held++;
            chk("dmem_req_hold", 32'({bus.dmem_req_valid, bus.dmem_we}), 32'({1'b1, store}));
        end
        bus.dmem_rsp_valid = 1'b0;
        bus.dmem_req_ready = 1'b1;
        @(negedge clk);
        bus.dmem_req_ready = 1'b0;
        chk("dmem_req_drop", 32'(bus.dmem_req_valid), 32'd0);
        for (int i = 0; i < dr; i++) @(negedge clk);
        bus.dmem_rsp_valid = 1'b1;
        @(negedge clk);
        bus.dmem_rsp_valid = 1'b0;
    endtask

    task automatic doInstr(input logic [31:0] ir, input int iw, input int rw, input int dw,
                           input int dr, input logic taken, output logic rf, output logic pc,
                           output logic [2:0] ext, output int held, output int lat);
        int t0;
        int expLat;
        held = 0;
        expLat = 5 + iw + rw + (isMemOp(ir) ? 2 + dw + dr : 0);
        fetch(ir, iw, rw, taken, 1'b1, t0);
        if (isMemOp(ir)) memPhase(ir[6:0] == 7'h23, dw, dr, held);
        waitFor("retire", 2);
        rf = bus.rf_we;
        pc = bus.pc_sel;
        ext = bus.ext_op;
        lat = cyc - t0 + 1;
        chk("latency", 32'(lat), 32'(expLat));
        @(negedge clk);
        chk("retire_once", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, required to finish", $time);
        $fatal(1);
    end

    initial begin : main
        logic rf, pc;
        logic [2:0] ext;
        int held, lat, t0;
        doReset();

        doInstr(32'h00500093, 0, 0, 0, 0, 1'b0, rf, pc, ext, held, lat);   // ADDI
        chk("addi_ext_op", 32'(ext), 32'd0);
        chk("addi_rf_we", 32'(rf), 32'd1);
        chk("addi_latency", 32'(lat), 32'd5);

        doInstr(32'h0000A103, 0, 0, 3, 1, 1'b0, rf, pc, ext, held, lat);   // LW, ready low 3
        chk("lw_req_held", 32'(held), 32'd4);
        chk("lw_rf_we", 32'(rf), 32'd1);
        chk("lw_latency", 32'(lat), 32'd11);

        doInstr(32'h00208463, 0, 0, 0, 0, 1'b1, rf, pc, ext, held, lat);   // BEQ taken
        chk("beq_ext_op", 32'(ext), 32'd3);
        chk("beq_pc_sel", 32'(pc), 32'd1);
        chk("beq_rf_we", 32'(rf), 32'd0);

        doInstr(32'h00209463, 2, 1, 0, 0, 1'b0, rf, pc, ext, held, lat);   // BNE not taken
        chk("bne_pc_sel", 32'(pc), 32'd0);

        doInstr(32'h0020A023, 1, 0, 1, 2, 1'b0, rf, pc, ext, held, lat);   // SW
        chk("sw_ext_op", 32'(ext), 32'd2);
        chk("sw_rf_we", 32'(rf), 32'd0);

        doInstr(32'h010000EF, 0, 0, 0, 0, 1'b0, rf, pc, ext, held, lat);   // JAL
        chk("jal_ext_op", 32'(ext), 32'd4);
        chk("jal_pc_sel", 32'(pc), 32'd1);

        doInstr(32'h00008067, 0, 2, 0, 0, 1'b0, rf, pc, ext, held, lat);   // JALR
        doInstr(32'h123452B7, 0, 0, 0, 0, 1'b1, rf, pc, ext, held, lat);   // LUI
        chk("lui_ext_op", 32'(ext), 32'd1);
        doInstr(32'h00000297, 0, 0, 0, 0, 1'b0, rf, pc, ext, held, lat);   // AUIPC
        doInstr(32'h002081B3, 0, 0, 0, 0, 1'b1, rf, pc, ext, held, lat);   // ADD
        doInstr(32'h00000073, 0, 0, 0, 0, 1'b0, rf, pc, ext, held, lat);   // ECALL as NOP
        chk("ecall_rf_we", 32'(rf), 32'd0);

`ifdef YSYX_25030081_CTRL_TRAP_EN
        fetch(32'h0000007F, 0, 0, 1'b0, 1'b0, t0);
        chk("unknown_trap_pre", 32'(bus.trap), 32'd0);
        @(negedge clk);
        chk("unknown_trap", 32'(bus.trap), 32'd1);
        repeat (5) @(negedge clk);
        doReset();

        waitFor("fetch_req", 0);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        repeat (255) @(negedge clk);
        chk("timeout_not_yet", 32'(bus.trap), 32'd0);
        @(negedge clk);
        chk("timeout_trap", 32'(bus.trap), 32'd1);
        repeat (5) @(negedge clk);
        doReset();
`else
        doInstr(32'h0000007F, 0, 0, 0, 0, 1'b1, rf, pc, ext, held, lat);   // unknown -> NOP
        chk("unknown_nop_rf_we", 32'(rf), 32'd0);
        chk("unknown_nop_pc_sel", 32'(pc), 32'd0);
        doInstr(32'h00500093, 0, 300, 0, 0, 1'b0, rf, pc, ext, held, lat); // no timeout
        chk("long_wait_latency", 32'(lat), 32'd305);
`endif

        fetch(32'h0020A023, 0, 0, 1'b0, 1'b1, t0);                         // reset during MREQ
        waitFor("dmem_req", 1);
        bus.dmem_req_ready = 1'b0;
        @(negedge clk);
        chk("mreq_hold", 32'(bus.dmem_req_valid), 32'd1);
        checkEn = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mreq_rst_dmem_req", 32'(bus.dmem_req_valid), 32'd0);
        chk("mreq_rst_inst", bus.inst, 32'h00000013);
        chk("mreq_rst_imem_req", 32'(bus.imem_req_valid), 32'd0);
        expQ.delete();
        rst_n = 1'b1;
        checkEn = 1'b1;
        @(negedge clk);
        chk("mreq_rst_refetch", 32'(bus.imem_req_valid), 32'd1);
        doInstr(32'h00500093, 0, 0, 0, 0, 1'b0, rf, pc, ext, held, lat);
        chk("post_reset_latency", 32'(lat), 32'd5);

        fetch(32'h00100073, 0, 0, 1'b0, 1'b0, t0);                         // EBREAK
        chk("halt_in_decode", 32'(bus.halt), 32'd0);
        @(negedge clk);
        chk("halt_set", 32'(bus.halt), 32'd1);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
